// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: shadowed codes, leading-zero blanking, per-digit blink.
// Latency: seg/dp_n/an_n/frame_tick registered, 1 cycle after the slot/index state that produces them.
// Backpressure: none; free-running scan, load is sampled on any cycle.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0]             slot_cnt;
  logic [IW-1:0]             idx;
  logic [FW-1:0]             frame_cnt;
  logic                      blink_phase;
  logic [5*NUM_DIGITS-1:0]   sh_dig;
  logic [NUM_DIGITS-1:0]     sh_dp;
  logic [NUM_DIGITS-1:0]     sh_blink;

  logic                      slot_tc;
  logic                      idx_last;
  logic [NUM_DIGITS-1:0]     supp;
  logic                      hi_zero;
  logic [4:0]                code_i;
  logic [4:0]                cur_code;
  logic                      an_act;
  logic                      blink_off;
  logic [6:0]                seg_nxt;
  logic                      dp_nxt;
  logic [NUM_DIGITS-1:0]     an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign slot_tc  = (slot_cnt == SLOT_LAST);
  assign idx_last = (idx == IDX_LAST);

  // Walk from the most significant digit down; a blank higher digit still counts as "leading".
  always_comb begin
    supp    = '0;
    hi_zero = 1'b1;
    code_i  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      code_i = sh_dig[5*i +: 5];
      if (i > 0 && lz_en && code_i == 5'h00 && hi_zero)
        supp[i] = 1'b1;
      hi_zero = hi_zero & ((code_i == 5'h00) | code_i[4]);
    end
  end

  always_comb begin
    cur_code  = sh_dig[5*idx +: 5];
    an_act    = (slot_cnt >= SLOT_BLANK);
    blink_off = blink_phase & sh_blink[idx];
    seg_nxt   = (cur_code[4] | supp[idx] | blink_off) ? 7'h7F : hex7(cur_code[3:0]);
    dp_nxt    = ~(sh_dp[idx] & ~blink_off & an_act);
    an_nxt    = '1;
    if (an_act)
      an_nxt[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_dig      <= {NUM_DIGITS{5'h10}};
      sh_dp       <= '0;
      sh_blink    <= '0;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      an_n        <= '1;
      frame_tick  <= 1'b0;
    end else begin
      if (load) begin
        sh_dig   <= digits;
        sh_dp    <= dp_in;
        sh_blink <= blink_mask;
      end
      slot_cnt <= slot_tc ? '0 : slot_cnt + 1'b1;
      if (slot_tc) begin
        idx <= idx_last ? '0 : idx + 1'b1;
        if (idx_last) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
      seg        <= seg_nxt;
      dp_n       <= dp_nxt;
      an_n       <= an_nxt;
      frame_tick <= slot_tc & idx_last;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a cycle-position reference model and hand-computed spot checks.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = SD * ND;

  logic          clk = 1'b0;
  logic          reset;
  logic [5*ND-1:0] digits;
  logic          load;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] blink_mask;
  logic          lz_en;
  logic [6:0]    seg;
  logic          dp_n;
  logic [ND-1:0] an_n;
  logic          frame_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int k      = 0;

  logic [6:0]    tab [16];
  logic [4:0]    m_dig [ND];
  logic [ND-1:0] m_dp;
  logic [ND-1:0] m_bm;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .digits(digits), .load(load), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_en(lz_en), .seg(seg), .dp_n(dp_n),
    .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int pos(input int f, input int d, input int s);
    return f * FRAME + d * SD + s;
  endfunction

  // Outputs after edge k reflect the scan state k-1 cycles after reset release.
  task automatic model_check();
    int n, s, d;
    logic act, blk, supp, hz;
    logic [4:0] code;
    logic [6:0] eseg;
    logic [ND-1:0] ean;
    n = k - 1;
    s = n % SD;
    d = (n / SD) % ND;
    act = (s >= BC);
    ean = '1;
    if (act) ean[d] = 1'b0;
    code = m_dig[d];
    hz = 1'b1;
    for (int j = ND - 1; j > d; j--) hz = hz & ((m_dig[j] == 5'h00) | m_dig[j][4]);
    supp = lz_en && (d > 0) && (code == 5'h00) && hz;
    blk  = (((n / (FRAME * BF)) % 2) == 1) && m_bm[d];
    eseg = (code[4] || supp || blk) ? 7'h7F : tab[code[3:0]];
    chk("an_n", an_n, ean);
    chk("seg", seg, eseg);
    chk("dp_n", dp_n, !(m_dp[d] && !blk && act));
    chk("frame_tick", frame_tick, (n % FRAME) == FRAME - 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    model_check();
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (k - 1 < n && guard < 3000) begin
      step();
      guard++;
    end
    if (k - 1 != n) begin
      n_chk++;
      $display("FAIL run_to: reached %0d required %0d", k - 1, n);
    end
  endtask

  task automatic do_load(input logic [5*ND-1:0] d, input logic [ND-1:0] dp, input logic [ND-1:0] bm);
    digits = d; dp_in = dp; blink_mask = bm; load = 1'b1;
    step();
    load = 1'b0;
    digits = 20'h5A5A5;
    dp_in = '1;
    blink_mask = '1;
    for (int i = 0; i < ND; i++) m_dig[i] = d[5*i +: 5];
    m_dp = dp;
    m_bm = bm;
  endtask

  // Load is held high during reset: the reset must win and keep the shadow blank.
  task automatic do_reset();
    reset = 1'b1; load = 1'b1; digits = 20'h12345; dp_in = '1; blink_mask = '1;
    @(posedge clk);
    #1;
    chk("rst an_n", an_n, 4'hF);
    chk("rst seg", seg, 7'h7F);
    chk("rst dp_n", dp_n, 1'b1);
    chk("rst frame_tick", frame_tick, 1'b0);
    reset = 1'b0; load = 1'b0;
    k = 0;
    for (int i = 0; i < ND; i++) m_dig[i] = 5'h10;
    m_dp = '0;
    m_bm = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = 7'h40; tab[1]  = 7'h79; tab[2]  = 7'h24; tab[3]  = 7'h30;
    tab[4]  = 7'h19; tab[5]  = 7'h12; tab[6]  = 7'h02; tab[7]  = 7'h78;
    tab[8]  = 7'h00; tab[9]  = 7'h10; tab[10] = 7'h08; tab[11] = 7'h03;
    tab[12] = 7'h46; tab[13] = 7'h21; tab[14] = 7'h06; tab[15] = 7'h0E;

    reset = 1'b1; load = 1'b0; lz_en = 1'b0;
    digits = '0; dp_in = '0; blink_mask = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic scan of 3,2,1,0
    do_load({5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000, 4'b0000);
    run_to(pos(0, 0, 1)); chk("dead slot0", an_n, 4'b1111);
    run_to(pos(0, 0, 2)); chk("an d0", an_n, 4'b1110); chk("seg d0", seg, 7'b1000000);
    run_to(pos(0, 1, 5)); chk("an d1", an_n, 4'b1101); chk("seg d1", seg, 7'b1111001);
    run_to(pos(0, 2, 7)); chk("an d2", an_n, 4'b1011); chk("seg d2", seg, 7'b0100100);
    run_to(pos(0, 3, 2)); chk("an d3", an_n, 4'b0111); chk("seg d3", seg, 7'b0110000);
    run_to(pos(0, 3, 7)); chk("tick at wrap", frame_tick, 1'b1);
    run_to(pos(1, 0, 0)); chk("tick one cycle", frame_tick, 1'b0);

    // Leading-zero suppression on 0,0,5,0
    lz_en = 1'b1;
    do_load({5'h00, 5'h00, 5'h05, 5'h00}, 4'b0000, 4'b0000);
    run_to(pos(2, 0, 4)); chk("lz d0 kept", seg, 7'b1000000);
    run_to(pos(2, 1, 4)); chk("lz d1", seg, 7'b0010010);
    run_to(pos(2, 2, 4)); chk("lz d2 supp", seg, 7'b1111111);
    run_to(pos(2, 3, 4)); chk("lz d3 supp", seg, 7'b1111111);
    lz_en = 1'b0;
    run_to(pos(3, 2, 4)); chk("nolz d2", seg, 7'b1000000);
    run_to(pos(3, 3, 4)); chk("nolz d3", seg, 7'b1000000);

    // Blank code and letter decode
    lz_en = 1'b1;
    do_load({5'h0F, 5'h0B, 5'h1A, 5'h00}, 4'b0000, 4'b0000);
    run_to(pos(4, 0, 4)); chk("code 00", seg, 7'b1000000);
    run_to(pos(4, 1, 4)); chk("code 1A", seg, 7'b1111111);
    run_to(pos(4, 2, 4)); chk("code 0B", seg, 7'b0000011);
    run_to(pos(4, 3, 4)); chk("code 0F", seg, 7'b0001110);

    // Mid-slot reset in digit 2
    run_to(pos(5, 2, 4)); chk("pre-rst an", an_n, 4'b1011);
    do_reset();
    lz_en = 1'b0;
    run_to(pos(0, 0, 4)); chk("post-rst an", an_n, 4'b1110); chk("post-rst blank", seg, 7'h7F);

    // Blink digit 0 with its decimal point
    do_load({5'h01, 5'h02, 5'h03, 5'h04}, 4'b0001, 4'b0001);
    run_to(pos(0, 0, 6)); chk("blk f0 seg", seg, 7'b0011001); chk("blk f0 dp", dp_n, 1'b0);
    run_to(pos(1, 0, 4)); chk("blk f1 seg", seg, 7'b0011001); chk("blk f1 dp", dp_n, 1'b0);
    run_to(pos(1, 1, 4)); chk("f1 d1 dp", dp_n, 1'b1);
    run_to(pos(2, 0, 4)); chk("blk f2 seg", seg, 7'h7F); chk("blk f2 dp", dp_n, 1'b1);
    chk("blk f2 an", an_n, 4'b1110);
    run_to(pos(2, 1, 4)); chk("f2 d1 seg", seg, 7'b0110000);
    run_to(pos(3, 0, 4)); chk("blk f3 seg", seg, 7'h7F);
    run_to(pos(4, 0, 1)); chk("dead dp", dp_n, 1'b1);
    run_to(pos(4, 0, 4)); chk("blk f4 seg", seg, 7'b0011001); chk("blk f4 dp", dp_n, 1'b0);

    // Load coinciding with terminal count of the last slot
    run_to(pos(4, 3, 6));
    do_load({5'h01, 5'h02, 5'h03, 5'h07}, 4'b0000, 4'b0000);
    chk("tc load tick", frame_tick, 1'b1);
    chk("tc load old d3", seg, 7'b1111001);
    run_to(pos(5, 0, 1)); chk("tc dead an", an_n, 4'b1111);
    run_to(pos(5, 0, 2)); chk("tc new an", an_n, 4'b1110); chk("tc new seg", seg, 7'b1111000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
